// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and constants for the multi-lane decode stage
//
// Purpose: opcode constants, ALU operation enum, memory-size codes and the
//          per-lane micro-op bundle (uop_t) used by decode_lane and decode_stage.
// Ports:   none (package).

package decode_pkg;

    // Widest program counter a micro-op can carry; decode_stage PC_W must not exceed it.
    localparam int UOP_PC_W = 32;

    localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPC_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_XOR  = 4'd1,
        ALU_OR   = 4'd2,
        ALU_SRA  = 4'd3,
        ALU_PASS = 4'd4
    } alu_op_e;

    typedef struct packed {
        logic                lane_vld;
        logic [UOP_PC_W-1:0] pc;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic [6:0]          opcode;
        alu_op_e             alu_op;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic [1:0]          mem_size;
        logic                illegal;
    } uop_t;

endpackage

// File: rtl/decode_lane.sv
// rtl/decode_lane.sv - combinational single-instruction decoder
//
// Purpose: decodes one 32-bit instruction into a uop_t bundle.
// Ports:   inst - instruction word
//          vld  - lane valid; when 0 the bundle is all zero
//          pc   - PC of this lane
//          uop  - decoded micro-op

module decode_lane
    import decode_pkg::*;
(
    input  logic [31:0]         inst,
    input  logic                vld,
    input  logic [UOP_PC_W-1:0] pc,
    output uop_t                uop
);

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] imm_sh;
    logic        legal;
    uop_t        d;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_sh = {26'b0, inst[25:20]};

    // Fields are only filled inside a recognised encoding, so an illegal
    // lane falls through with every operand and enable already zero.
    always_comb begin
        d     = '0;
        legal = 1'b0;
        case (opcode)
            OPC_R_TYPE: begin
                if (funct7 == 7'b0 && (funct3 == 3'b000 || funct3 == 3'b100)) begin
                    legal       = 1'b1;
                    d.rd        = rd;
                    d.rs1       = rs1;
                    d.rs2       = rs2;
                    d.reg_write = 1'b1;
                    d.alu_op    = (funct3 == 3'b100) ? ALU_XOR : ALU_ADD;
                end
            end
            OPC_I_TYPE: begin
                if (funct3 == 3'b000 || funct3 == 3'b110 ||
                    (funct3 == 3'b101 && inst[31:26] == 6'b010000)) begin
                    legal       = 1'b1;
                    d.rd        = rd;
                    d.rs1       = rs1;
                    d.reg_write = 1'b1;
                    d.alu_src   = 1'b1;
                    case (funct3)
                        3'b110:  begin d.alu_op = ALU_OR;  d.imm = imm_i;  end
                        3'b101:  begin d.alu_op = ALU_SRA; d.imm = imm_sh; end
                        default: begin d.alu_op = ALU_ADD; d.imm = imm_i;  end
                    endcase
                end
            end
            OPC_LOAD: begin
                if (funct3 == 3'b000 || funct3 == 3'b010) begin
                    legal       = 1'b1;
                    d.rd        = rd;
                    d.rs1       = rs1;
                    d.imm       = imm_i;
                    d.alu_src   = 1'b1;
                    d.mem_read  = 1'b1;
                    d.reg_write = 1'b1;
                    d.mem_size  = funct3[1] ? MEM_SIZE_WORD : MEM_SIZE_BYTE;
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b000 || funct3 == 3'b010) begin
                    legal       = 1'b1;
                    d.rs1       = rs1;
                    d.rs2       = rs2;
                    d.imm       = imm_s;
                    d.alu_src   = 1'b1;
                    d.mem_write = 1'b1;
                    d.mem_size  = funct3[1] ? MEM_SIZE_WORD : MEM_SIZE_BYTE;
                end
            end
            OPC_LUI: begin
                legal       = 1'b1;
                d.rd        = rd;
                d.imm       = imm_u;
                d.alu_src   = 1'b1;
                d.reg_write = 1'b1;
                d.alu_op    = ALU_PASS;
            end
            default: ;
        endcase

        // x0 is hardwired; suppress the write but still report rd.
        d.reg_write = d.reg_write & (d.rd != 5'd0);
        d.illegal   = ~legal;
        d.opcode    = opcode;
        d.pc        = pc;
        d.lane_vld  = 1'b1;
        uop         = vld ? d : '0;
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - WIDTH-lane decode stage with a two-entry skid buffer
//
// Purpose: decodes a fetch packet of up to WIDTH instructions and buffers the
//          result in a two-entry skid buffer with valid/ready handshaking.
// Ports:   clk, rst_n (async active-low), flush
//          in_valid/in_ready, in_inst, in_lane_vld, in_pc   - fetch side
//          out_valid/out_ready, out_* per-lane micro-op      - rename side
// PC_W must not exceed decode_pkg::UOP_PC_W.

module decode_stage
    import decode_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH*32-1:0]   in_inst,
    input  logic [WIDTH-1:0]      in_lane_vld,
    input  logic [PC_W-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_lane_vld,
    output logic [WIDTH*PC_W-1:0] out_pc,
    output logic [WIDTH*5-1:0]    out_rd,
    output logic [WIDTH*5-1:0]    out_rs1,
    output logic [WIDTH*5-1:0]    out_rs2,
    output logic [WIDTH*32-1:0]   out_imm,
    output logic [WIDTH*7-1:0]    out_opcode,
    output logic [WIDTH*4-1:0]    out_alu_op,
    output logic [WIDTH-1:0]      out_alu_src,
    output logic [WIDTH-1:0]      out_mem_read,
    output logic [WIDTH-1:0]      out_mem_write,
    output logic [WIDTH-1:0]      out_reg_write,
    output logic [WIDTH*2-1:0]    out_mem_size,
    output logic [WIDTH-1:0]      out_illegal
);

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    uop_t [WIDTH-1:0] dec;
    uop_t [WIDTH-1:0] head;
    uop_t [WIDTH-1:0] slot0_q, slot0_d;
    uop_t [WIDTH-1:0] slot1_q, slot1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             push;
    logic             deq;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        logic [PC_W-1:0] lane_pc;
        assign lane_pc = in_pc + PC_W'(4 * g);
        decode_lane u_lane (
            .inst (in_inst[32*g +: 32]),
            .vld  (in_lane_vld[g]),
            .pc   (UOP_PC_W'(lane_pc)),
            .uop  (dec[g])
        );
    end

    assign out_valid = (cnt_q != CNT_EMPTY);
    assign in_ready  = in_ready_q;
    // Empty packets complete the handshake but never occupy a slot.
    assign push      = in_valid & in_ready_q & (|in_lane_vld) & ~flush;
    assign deq       = out_valid & out_ready;

    // slot0 is always the oldest entry; a dequeue shifts slot1 down and the
    // new packet lands in the first free slot after that shift.
    always_comb begin
        cnt_d   = cnt_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        if (deq) begin
            slot0_d = slot1_q;
            cnt_d   = cnt_q - 2'd1;
        end
        if (push) begin
            if (cnt_d == CNT_EMPTY) begin
                slot0_d = dec;
            end else begin
                slot1_d = dec;
            end
            cnt_d = cnt_d + 2'd1;
        end
        if (flush) begin
            cnt_d = CNT_EMPTY;
        end
        // Registered ready looks only at next occupancy, so out_ready never
        // reaches in_ready combinationally.
        in_ready_d = (cnt_d == CNT_EMPTY) || (cnt_d == CNT_ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= CNT_EMPTY;
            in_ready_q <= 1'b0;
            slot0_q    <= '0;
            slot1_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
        end
    end

    // Outputs read zero whenever nothing is valid, hiding stale slot contents.
    assign head = out_valid ? slot0_q : '0;

    always_comb begin
        out_lane_vld  = '0;
        out_pc        = '0;
        out_rd        = '0;
        out_rs1       = '0;
        out_rs2       = '0;
        out_imm       = '0;
        out_opcode    = '0;
        out_alu_op    = '0;
        out_alu_src   = '0;
        out_mem_read  = '0;
        out_mem_write = '0;
        out_reg_write = '0;
        out_mem_size  = '0;
        out_illegal   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_lane_vld[i]        = head[i].lane_vld;
            out_pc[i*PC_W +: PC_W] = head[i].pc[PC_W-1:0];
            out_rd[i*5 +: 5]       = head[i].rd;
            out_rs1[i*5 +: 5]      = head[i].rs1;
            out_rs2[i*5 +: 5]      = head[i].rs2;
            out_imm[i*32 +: 32]    = head[i].imm;
            out_opcode[i*7 +: 7]   = head[i].opcode;
            out_alu_op[i*4 +: 4]   = head[i].alu_op;
            out_alu_src[i]         = head[i].alu_src;
            out_mem_read[i]        = head[i].mem_read;
            out_mem_write[i]       = head[i].mem_write;
            out_reg_write[i]       = head[i].reg_write;
            out_mem_size[i*2 +: 2] = head[i].mem_size;
            out_illegal[i]         = head[i].illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage

module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_inst;
    logic [1:0]  in_lane_vld;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_lane_vld;
    logic [63:0] out_pc;
    logic [9:0]  out_rd;
    logic [9:0]  out_rs1;
    logic [9:0]  out_rs2;
    logic [63:0] out_imm;
    logic [13:0] out_opcode;
    logic [7:0]  out_alu_op;
    logic [1:0]  out_alu_src;
    logic [1:0]  out_mem_read;
    logic [1:0]  out_mem_write;
    logic [1:0]  out_reg_write;
    logic [3:0]  out_mem_size;
    logic [1:0]  out_illegal;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    decode_stage #(.WIDTH(2), .PC_W(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_lane_vld   (in_lane_vld),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_lane_vld  (out_lane_vld),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_imm       (out_imm),
        .out_opcode    (out_opcode),
        .out_alu_op    (out_alu_op),
        .out_alu_src   (out_alu_src),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_reg_write (out_reg_write),
        .out_mem_size  (out_mem_size),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i1, input logic [31:0] i0,
                         input logic [1:0] lv, input logic [31:0] pc);
        in_valid    = v;
        in_inst     = {i1, i0};
        in_lane_vld = lv;
        in_pc       = pc;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_pc", out_pc, 64'd0);
        rst_n = 1'b1;
        step();
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);

        // Basic decode: ADD x3,x1,x2 / ADDI x5,x0,-1
        out_ready = 1'b1;
        drive(1'b1, 32'hFFF00293, 32'h002081B3, 2'b11, 32'h100);
        step();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_l0_rd", 64'(out_rd[4:0]), 64'd3);
        check("t1_l0_rs1", 64'(out_rs1[4:0]), 64'd1);
        check("t1_l0_rs2", 64'(out_rs2[4:0]), 64'd2);
        check("t1_l0_alu", 64'(out_alu_op[3:0]), 64'd0);
        check("t1_l0_pc", 64'(out_pc[31:0]), 64'h100);
        check("t1_l0_rw", 64'(out_reg_write[0]), 64'd1);
        check("t1_l1_rd", 64'(out_rd[9:5]), 64'd5);
        check("t1_l1_imm", 64'(out_imm[63:32]), 64'hFFFFFFFF);
        check("t1_l1_src", 64'(out_alu_src[1]), 64'd1);
        check("t1_l1_pc", 64'(out_pc[63:32]), 64'h104);

        // Immediate formats: LUI x7 / SRAI x4,x1,3
        drive(1'b1, 32'h4030D213, 32'h123453B7, 2'b11, 32'h200);
        step();
        check("t2_l0_imm", 64'(out_imm[31:0]), 64'h12345000);
        check("t2_l0_alu", 64'(out_alu_op[3:0]), 64'd4);
        check("t2_l0_rd", 64'(out_rd[4:0]), 64'd7);
        check("t2_l1_rd", 64'(out_rd[9:5]), 64'd4);
        check("t2_l1_imm", 64'(out_imm[63:32]), 64'd3);
        check("t2_l1_alu", 64'(out_alu_op[7:4]), 64'd3);

        // Store and illegal: SB x2,4(x1) / opcode 0x7F
        drive(1'b1, 32'h0000007F, 32'h00208223, 2'b11, 32'h300);
        step();
        check("t3_l0_rs1", 64'(out_rs1[4:0]), 64'd1);
        check("t3_l0_rs2", 64'(out_rs2[4:0]), 64'd2);
        check("t3_l0_imm", 64'(out_imm[31:0]), 64'd4);
        check("t3_l0_size", 64'(out_mem_size[1:0]), 64'd0);
        check("t3_l0_mw", 64'(out_mem_write[0]), 64'd1);
        check("t3_l0_rw", 64'(out_reg_write[0]), 64'd0);
        check("t3_l0_ill", 64'(out_illegal[0]), 64'd0);
        check("t3_l1_ill", 64'(out_illegal[1]), 64'd1);
        check("t3_l1_vld", 64'(out_lane_vld[1]), 64'd1);
        check("t3_l1_en", 64'({out_reg_write[1], out_mem_read[1], out_mem_write[1]}), 64'd0);
        check("t3_l1_ops", 64'({out_rd[9:5], out_rs1[9:5], out_rs2[9:5], out_imm[63:32]}), 64'd0);

        drive(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
        step();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: A, B accepted, C held, then drained in order
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h00100093, 2'b11, 32'hA00);
        step();
        check("bp_a_valid", 64'(out_valid), 64'd1);
        check("bp_a_ready", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h00100093, 32'h00100093, 2'b11, 32'hB00);
        step();
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_head_a", 64'(out_pc[31:0]), 64'hA00);
        drive(1'b1, 32'h00100093, 32'h00100093, 2'b11, 32'hC00);
        step();
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        check("bp_hold_a", 64'(out_pc[31:0]), 64'hA00);
        out_ready = 1'b1;
        step();
        check("bp_head_b", 64'(out_pc[31:0]), 64'hB00);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        check("bp_head_c", 64'(out_pc[31:0]), 64'hC00);
        check("bp_c_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
        step();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush while FULL with a simultaneous packet
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h00100093, 2'b11, 32'h500);
        step();
        drive(1'b1, 32'h00100093, 32'h00100093, 2'b11, 32'h600);
        step();
        check("fl_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'h00100093, 32'h00100093, 2'b11, 32'h700);
        step();
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        // Flush from ONE with a packet that does complete its handshake
        flush = 1'b0;
        drive(1'b1, 32'h00100093, 32'h00100093, 2'b11, 32'h800);
        step();
        check("fl1_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        drive(1'b1, 32'h00100093, 32'h00100093, 2'b11, 32'h900);
        step();
        check("fl1_flushed", 64'(out_valid), 64'd0);
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
        step();
        check("fl1_no_ghost", 64'(out_valid), 64'd0);

        // Reset mid-stream clears outputs without a clock edge
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h00100093, 2'b11, 32'hD00);
        step();
        check("rst_pre_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_ready", 64'(in_ready), 64'd0);
        check("rst_async_pc", out_pc, 64'd0);
        check("rst_async_lv", 64'(out_lane_vld), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_rel_ready", 64'(in_ready), 64'd1);

        // Empty packet: accepted, never becomes valid
        out_ready = 1'b1;
        drive(1'b1, 32'h00100093, 32'h00100093, 2'b00, 32'hE00);
        step();
        check("empty_valid", 64'(out_valid), 64'd0);
        check("empty_ready", 64'(in_ready), 64'd1);

        // ADDI x0 in both lanes, PC wraps past the top of the address space
        drive(1'b1, 32'h00100013, 32'h00100013, 2'b11, 32'hFFFFFFFC);
        step();
        check("x0_valid", 64'(out_valid), 64'd1);
        check("x0_l0_rw", 64'(out_reg_write[0]), 64'd0);
        check("x0_l0_ill", 64'(out_illegal[0]), 64'd0);
        check("x0_l0_imm", 64'(out_imm[31:0]), 64'd1);
        check("x0_l1_pc_wrap", 64'(out_pc[63:32]), 64'd0);
        check("x0_l1_vld", 64'(out_lane_vld[1]), 64'd1);

        // Invalid lane 1 yields an all-zero bundle
        drive(1'b1, 32'h002081B3, 32'h00100093, 2'b01, 32'h40);
        step();
        check("inv_l0_rw", 64'(out_reg_write[0]), 64'd1);
        check("inv_l1_vld", 64'(out_lane_vld[1]), 64'd0);
        check("inv_l1_bundle", 64'({out_rd[9:5], out_rs1[9:5], out_rs2[9:5], out_opcode[13:7], out_pc[63:32]}), 64'd0);

        drive(1'b0, 32'h0, 32'h0, 2'b00, 32'h0);
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised multi-lane instruction decode stage with valid/ready handshaking. It accepts a packet of up to `WIDTH` instructions from fetch and decodes each lane into a micro-op bundle. Results are buffered in a two-entry skid buffer so that backpressure from rename/issue never drops a packet. Unsupported encodings are flagged per lane rather than silently discarded. A flush input empties the stage in one cycle.

## Interface
- `WIDTH`, 2, number of decode lanes per packet (1..4)
- `PC_W`, 32, program-counter width
- Reset `rst_n`, asynchronous, active-low; clock `clk`.
- `clk` in 1 — clock, rising edge
- `rst_n` in 1 — asynchronous active-low reset
- `flush` in 1 — discard all buffered and incoming packets
- `in_valid` in 1 — fetch packet valid
- `in_ready` out 1 — stage can accept a packet
- `in_inst` in WIDTH*32 — lane i at bits [32i+31:32i]
- `in_lane_vld` in WIDTH — per-lane instruction valid
- `in_pc` in PC_W — PC of lane 0
- `out_valid` out 1 — decoded packet valid
- `out_ready` in 1 — downstream accepts the packet
- `out_lane_vld` out WIDTH — per-lane valid
- `out_pc` out WIDTH*PC_W — per-lane PC
- `out_rd`, `out_rs1`, `out_rs2` out WIDTH*5 — register specifiers
- `out_imm` out WIDTH*32 — immediate
- `out_opcode` out WIDTH*7 — raw opcode
- `out_alu_op` out WIDTH*4 — encoding: ADD=0, XOR=1, OR=2, SRA=3, PASS=4
- `out_alu_src`, `out_mem_read`, `out_mem_write`, `out_reg_write`, `out_illegal` out WIDTH — per-lane control bits
- `out_mem_size` out WIDTH*2 — 00 = byte, 10 = word

## Operation
- **Per-lane decode (combinational).** Supported instructions: ADD, XOR (R); ADDI, ORI, SRAI (I); LB, LW; SB, SW; LUI.
  - Immediates are built per RISC-V format.
  - SRAI immediate = zero-extended shamt.
  - LUI immediate = {inst[31:12], 12'b0}, with `alu_op` = PASS.
- **Lane PC.** `out_pc` for lane i = `in_pc` + 4*i, modulo 2^PC_W.
- **Illegal lanes.** Any other opcode, funct3 or funct7, including SRAI with inst[31:26] ≠ 010000, is illegal. The lane stays valid with `illegal`=1; `reg_write`, `mem_read`, `mem_write`, `rd`, `rs1`, `rs2` and `imm` are all 0.
- **Writes to x0.** `reg_write` is forced to 0 when `rd` = 0. `rd` is still reported.
- **Invalid lanes.** A lane with `in_lane_vld`=0 produces an all-zero bundle with `lane_vld`=0.
- **Empty packets.** A packet whose `in_lane_vld` is all zero is accepted (handshake completes) but not enqueued.
- **Skid buffer.** Two entries, with count states EMPTY (0), ONE (1), FULL (2).
  - Enqueue when `in_valid` & `in_ready`.
  - Dequeue when `out_valid` & `out_ready`.
  - Transitions:
    - EMPTY + enq → ONE
    - ONE + enq, no deq → FULL
    - ONE + deq, no enq → EMPTY
    - ONE + enq + deq → ONE
    - FULL + deq → ONE
  - Outputs always present the oldest entry; packet order is preserved.
- **Flush.** `flush` has priority over everything. The next state is EMPTY, and any packet presented in the same cycle is dropped (the handshake still completes if `in_ready`=1).

## Timing
- **Reset.** All outputs are 0, including `in_ready`=0 and `out_valid`=0. `in_ready` rises on the first clock edge after `rst_n` deasserts. Reset mid-operation discards all entries immediately.
- **Latency.** A packet accepted at edge N appears with `out_valid`=1 after edge N (registered, 1 cycle).
- **Throughput.** One packet per cycle while `out_ready`=1.
- **`in_ready`.** Registered; equals (next count < 2). It drops only when FULL, so no combinational path exists from `out_ready` to `in_ready`.
- **Output stability.** While `out_valid`=1 and `out_ready`=0, all `out_*` signals hold stable.
- **Flush timing.** After `flush` at edge N: `out_valid`=0 and `in_ready`=1 after edge N.

## Structure
- **`decode_pkg`:**
  - opcode constants (R_TYPE, I_TYPE, LOAD, STORE, LUI);
  - `alu_op_e` enum;
  - mem-size constants;
  - `uop_t` struct {lane_vld, pc, rd, rs1, rs2, imm, opcode, alu_op, alu_src, mem_read, mem_write, reg_write, mem_size, illegal}.
- **Sub-module `decode_lane`.** Purely combinational single-instruction decoder (inst, vld, pc → `uop_t`), instantiated WIDTH times by generate.
- **Top level.** Holds the skid buffer (2 × WIDTH × `uop_t`), the count register and the handshake logic.

## Test plan
1. **Basic decode.** WIDTH=2, `in_pc`=0x100, inst {0x002081B3, 0xFFF00293}, `out_ready`=1.
   - One cycle later, lane 0: ADD, rd=3, rs1=1, rs2=2, `pc`=0x100.
   - Lane 1: ADDI, rd=5, imm=0xFFFFFFFF, `alu_src`=1, `pc`=0x104.
2. **Immediate formats.** Lanes {0x123453B7, 0x4030D213}.
   - Lane 0: LUI, imm=0x12345000, `alu_op`=PASS.
   - Lane 1: SRAI, rd=4, imm=3, `alu_op`=SRA.
3. **Store and illegal.** Lanes {0x00208223, 0x0000007F}.
   - Lane 0: SB, rs1=1, rs2=2, imm=4, `mem_size`=00, `mem_write`=1, `reg_write`=0.
   - Lane 1: `illegal`=1, `lane_vld`=1, all write enables 0.
4. **Backpressure.** `out_ready`=0, push packets A, B, C.
   - A and B are accepted; `in_ready`=0 while C is held.
   - With `out_ready`=1, the output order is A, B, then C is accepted, with no loss or duplication.
5. **Flush.** `flush` while FULL, with a simultaneous `in_valid`.
   - Next cycle: `out_valid`=0, `in_ready`=1; the dropped packet never appears.
6. **Reset and edge cases.** Assert `rst_n` mid-stream → all outputs 0 immediately. Then:
   - an all-zero `in_lane_vld` packet is accepted but produces no `out_valid`;
   - ADDI x0 (0x00100013) gives `reg_write`=0.
